// File: rtl/calc_disp_pkg.sv
// Shared types and segment patterns for the calculator result display.
// Segment vectors are active-high, bit order g..a.
package calc_disp_pkg;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ZERO  = 7'b0111111;

  // Codes 10-15 can never leave the converter, but still decode to blank.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_pattern = 7'b0111111;
      4'd1:    seg_pattern = 7'b0000110;
      4'd2:    seg_pattern = 7'b1011011;
      4'd3:    seg_pattern = 7'b1001111;
      4'd4:    seg_pattern = 7'b1100110;
      4'd5:    seg_pattern = 7'b1101101;
      4'd6:    seg_pattern = 7'b1111101;
      4'd7:    seg_pattern = 7'b0000111;
      4'd8:    seg_pattern = 7'b1111111;
      4'd9:    seg_pattern = 7'b1101111;
      default: seg_pattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// One BCD digit to active-high 7-segment pattern (g..a), with forced blanking.
module seven_seg_decoder
  import calc_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_pattern(bcd_i);

endmodule

// File: rtl/result_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS 7-segment displays.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above the units digit.
module result_bcd_display
  import calc_disp_pkg::*;
#(
  parameter int IN_W           = 7,
  parameter int DIGITS         = 3,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_value,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int BW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic              done_q, done_d;

  logic [BW-1:0]       adj_s;
  logic [BW+IN_W-1:0]  cat_s;
  logic [BW-1:0]       scratch_next_s;
  logic [IN_W-1:0]     shift_next_s;
  logic [DIGITS-1:0]   blank_s;
  logic [6:0]          dec_s [DIGITS];
  logic [7*DIGITS-1:0] seg_next_s;
  logic [7*DIGITS-1:0] seg_rst_s;

  // One double-dabble step: add-3 correction on every digit, then shift left.
  always_comb begin
    adj_s = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = scratch_q[4*i +: 4];
      end
    end
    cat_s = {adj_s, shift_q} << 1'b1;
  end

  assign scratch_next_s = cat_s[BW+IN_W-1:IN_W];
  assign shift_next_s   = cat_s[IN_W-1:0];

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above_s;

  // A digit is blank when it and every digit above it are zero; units never blank.
  always_comb begin
    blank_s      = '0;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above_s = zero_above_s & (scratch_next_s[4*i +: 4] == 4'd0);
      blank_s[i]   = zero_above_s;
    end
  end
`else
  assign blank_s = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seven_seg_decoder u_dec (
      .bcd_i   (scratch_next_s[4*g +: 4]),
      .blank_i (blank_s[g]),
      .seg_o   (dec_s[g])
    );
  end

  // Board polarity for the freshly converted digits and for the reset display.
  always_comb begin
    seg_next_s = '0;
    seg_rst_s  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_next_s[7*i +: 7] = SEG_ACTIVE_LOW ? ~dec_s[i] : dec_s[i];
`ifdef LEADING_ZERO_BLANK_EN
      seg_rst_s[7*i +: 7]  = (i == 0) ? (SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO)
                                      : (SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK);
`else
      seg_rst_s[7*i +: 7]  = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
`endif
    end
  end

  // Control FSM: load in IDLE, shift IN_W times in CONV, latch on the last shift.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    seg_d     = seg_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = in_value;
          scratch_d = '0;
          cnt_d     = CW'(IN_W);
          state_d   = CONV;
        end else begin
          state_d   = IDLE;
        end
      end
      CONV: begin
        shift_d   = shift_next_s;
        scratch_d = scratch_next_s;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = scratch_next_s;
          seg_d   = seg_next_s;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CONV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      seg_q     <= seg_rst_s;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      seg_q     <= seg_d;
      done_q    <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench for result_bcd_display; honours LEADING_ZERO_BLANK_EN when defined.
module tb_result_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  in_value;
  logic        ready;
  logic        done;
  logic [11:0] bcd;
  logic [20:0] seg;

  int checks = 0;
  int fails  = 0;
  int unsigned cyc = 0;
  int unsigned last_done_cyc = 0;
  int unsigned prev_done_cyc = 0;
  int busy_cnt = 0;

  typedef struct packed {
    logic [11:0] bcd;
    logic [20:0] seg;
    int unsigned acc;
  } exp_t;
  exp_t sb[$];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [20:0] RST_SEG = {7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [20:0] SEG_7   = {7'b1111111, 7'b1111111, 7'b1111000};
`else
  localparam logic [20:0] RST_SEG = {7'b1000000, 7'b1000000, 7'b1000000};
  localparam logic [20:0] SEG_7   = {7'b1000000, 7'b1000000, 7'b1111000};
`endif
  localparam logic [20:0] SEG_127 = {7'b1111001, 7'b0100100, 7'b1111000};

  result_bcd_display dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_value (in_value),
    .ready    (ready),
    .done     (done),
    .bcd      (bcd),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Active-low board patterns, g..a.
  function automatic logic [6:0] tb_pat(input int d);
    logic [6:0] p;
    case (d)
      0: p = 7'b1000000;  1: p = 7'b1111001;  2: p = 7'b0100100;
      3: p = 7'b0110000;  4: p = 7'b0011001;  5: p = 7'b0010010;
      6: p = 7'b0000010;  7: p = 7'b1111000;  8: p = 7'b0000000;
      9: p = 7'b0010000;  default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  function automatic logic [11:0] model_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100); t = 4'((v / 10) % 10); u = 4'(v % 10);
    return {h, t, u};
  endfunction

  function automatic logic [20:0] model_seg(input int v);
    logic [6:0] hs, ts;
    hs = tb_pat(v / 100);
    ts = tb_pat((v / 10) % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 100) hs = 7'b1111111;
    if (v < 10)  ts = 7'b1111111;
`endif
    return {hs, ts, tb_pat(v % 10)};
  endfunction

  // Monitor: pops the scoreboard on every done pulse and tracks busy length.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (!ready) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        checks++;
        if (busy_cnt != 7) begin
          fails++;
          $display("FAIL busy_len got=%0d exp=7", busy_cnt);
        end
        busy_cnt = 0;
      end
      if (done) begin
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done bcd=%h", bcd);
        end else begin
          e = sb.pop_front();
          if (bcd !== e.bcd) begin
            fails++;
            $display("FAIL bcd got=%h exp=%h", bcd, e.bcd);
          end
          checks++;
          if (seg !== e.seg) begin
            fails++;
            $display("FAIL seg got=%b exp=%b", seg, e.seg);
          end
          checks++;
          if (cyc - e.acc != 7) begin
            fails++;
            $display("FAIL latency got=%0d exp=7", cyc - e.acc);
          end
        end
      end
    end
  end

  task automatic send(input logic [6:0] v, input logic [11:0] eb,
                      input logic [20:0] es, input bit expect_done);
    int n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) begin
      checks++; fails++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (expect_done) sb.push_back('{eb, es, cyc});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic check_idle_reset(input string name);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || bcd !== 12'h000 || seg !== RST_SEG) begin
      fails++;
      $display("FAIL %s got ready=%b done=%b bcd=%h seg=%b exp 1 0 000 %b",
               name, ready, done, bcd, seg, RST_SEG);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_value = 7'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_reset("reset_state");
    rst_n = 1'b1;

    send(7'd0,   12'h000, RST_SEG, 1'b1);
    drain();
    send(7'd127, 12'h127, SEG_127, 1'b1);
    drain();

    // Busy period: 99 offered during conversion of 45 must be dropped.
    send(7'd45, 12'h045, model_seg(45), 1'b1);
    in_valid = 1'b1;
    in_value = 7'd99;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(7'd99, 12'h099, model_seg(99), 1'b1);
    drain();
    checks++;
    if (last_done_cyc - prev_done_cyc != 8) begin
      fails++;
      $display("FAIL back_to_back gap got=%0d exp=8", last_done_cyc - prev_done_cyc);
    end

    // Abort a conversion of 100 with reset in its fourth cycle.
    send(7'd100, 12'h100, model_seg(100), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset("reset_abort");
    repeat (12) @(posedge clk);
    #1;

    for (int v = 0; v < 128; v++) begin
      send(7'(v), model_bcd(v), model_seg(v), 1'b1);
    end
    drain();

    send(7'd7,   12'h007, SEG_7, 1'b1);
    send(7'd100, 12'h100, {7'b1111001, 7'b1000000, 7'b1000000}, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
